// File: rtl/ff_dly_line.sv
// Run-time selectable delay line: a shift register of up to gp_max_dly enabled samples
// with a tap mux, fill tracking for a valid flag, synchronous clear and a delay-load strobe.
module ff_dly_line #(
  parameter int gp_data_width = 8,
  parameter int gp_max_dly    = 8,
  parameter int gp_dly_width  = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_an,
  input  logic                     i_ena,
  input  logic                     i_clr,
  input  logic                     i_ld,
  input  logic [gp_dly_width-1:0]  i_dly,
  input  logic [gp_data_width-1:0] i_data,
  output logic [gp_data_width-1:0] o_data,
  output logic                     o_vld,
  output logic [gp_dly_width-1:0]  o_dly
);

  localparam logic [gp_dly_width-1:0] LP_MAX = gp_dly_width'(gp_max_dly);
  localparam logic [gp_dly_width-1:0] LP_ONE = gp_dly_width'(1);

  logic [gp_data_width-1:0] r_stage [gp_max_dly];
  logic [gp_dly_width-1:0]  r_dly;
  logic [gp_dly_width-1:0]  r_fill;
  logic [gp_dly_width-1:0]  w_dly_clamped;
  logic [gp_data_width-1:0] w_tap;

  // A requested delay of zero is meaningless for a register line, so it maps to one.
  always_comb begin
    w_dly_clamped = i_dly;
    if (i_dly == '0) begin
      w_dly_clamped = LP_ONE;
    end else if (i_dly > LP_MAX) begin
      w_dly_clamped = LP_MAX;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      for (int k = 0; k < gp_max_dly; k++) begin
        r_stage[k] <= '0;
      end
      r_dly  <= LP_MAX;
      r_fill <= '0;
    end else begin
      if (i_ld) begin
        r_dly <= w_dly_clamped;
      end
      if (i_clr) begin
        for (int k = 0; k < gp_max_dly; k++) begin
          r_stage[k] <= '0;
        end
        r_fill <= '0;
      end else begin
        if (i_ena) begin
          r_stage[0] <= i_data;
          for (int k = 1; k < gp_max_dly; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
        // A load restarts the fill count so o_vld flags the delay discontinuity.
        if (i_ld) begin
          r_fill <= i_ena ? LP_ONE : '0;
        end else if (i_ena && (r_fill != LP_MAX)) begin
          r_fill <= r_fill + LP_ONE;
        end
      end
    end
  end

  // r_dly is always within 1..gp_max_dly, so exactly one tap matches.
  always_comb begin
    w_tap = '0;
    for (int k = 0; k < gp_max_dly; k++) begin
      if (r_dly == gp_dly_width'(k + 1)) begin
        w_tap = r_stage[k];
      end
    end
  end

  assign o_data = w_tap;
  assign o_vld  = (r_fill >= r_dly);
  assign o_dly  = r_dly;

endmodule

// File: doc/ff_dly_line.md
Name: ff_dly_line

Overview:
- Parametrised successor of the single enable flip-flop: a multi-stage delay line whose delay is selectable at run time (1..gp_max_dly enabled samples).
- Adds a fill/valid indicator, a synchronous clear and a delay-load strobe.
- Sits in the CIC comb sections (differential delay M) and in the general DSP pipeline-alignment paths, clocked at the sample rate via i_ena.

Parameters:
- gp_data_width, 8, input/output bit-width (signed or unsigned; the block is data-agnostic).
- gp_max_dly, 8, maximum delay in enabled samples; legal range 1..64.
- gp_dly_width, 6, width of i_dly; must satisfy 2**gp_dly_width > gp_max_dly.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_an  input  1  synchronous active-low reset
- i_ena  input  1  synchronous active-high sample enable (shift strobe)
- i_clr  input  1  synchronous active-high clear of the stage array and fill counter
- i_ld  input  1  synchronous active-high load strobe for i_dly
- i_dly  input  gp_dly_width  requested delay, in enabled samples
- i_data  input  gp_data_width  input sample
- o_data  output  gp_data_width  delayed sample
- o_vld  output  1  high when the line holds at least r_dly enabled samples since the last reset/clear/load
- o_dly  output  gp_dly_width  currently active (clamped) delay

Behaviour:
- Reset (i_rst_an=0 at a rising edge): all stages = 0, r_dly = gp_max_dly, fill counter = 0. Outputs: o_data=0, o_vld=0, o_dly=gp_max_dly. Reset overrides every other input.
- Storage: gp_max_dly registers s[0..gp_max_dly-1].
  - On i_ena=1: s[0]<=i_data and s[k]<=s[k-1].
  - On i_ena=0: all stages hold.
- Output: o_data = s[r_dly-1], a combinational tap mux from registers (no extra register).
  - With delay D, o_data equals the i_data sampled at the D-th most recent enabled edge.
  - D=1 reproduces the plain enable flip-flop exactly.
- Delay load: on i_ld=1, r_dly <= clamp(i_dly).
  - clamp: 0 -> 1; values > gp_max_dly -> gp_max_dly; otherwise unchanged.
  - o_dly reflects the new value from the next cycle. The tap switch takes effect on the same edge.
- Fill counter: saturating at gp_max_dly; increments on each enabled edge.
  - o_vld = (fill >= r_dly), evaluated combinationally from registered fill and r_dly.
- Load restarts fill: on i_ld, fill <= (i_ena ? 1 : 0). Stage contents are kept, but o_vld drops until refilled.
- Clear: on i_clr=1, all stages <= 0 and fill <= 0. i_data is not captured on that edge even if i_ena=1.
- Priority at one edge: reset > clear > normal shift.
  - i_clr and i_ld together: the array clears, r_dly loads, and fill = 0.
  - i_ld and i_ena together: the shift happens and r_dly loads.
- Reducing D mid-stream: o_vld stays low until r_dly new enabled samples arrive, even though the older data is present. This is intentional, to flag the discontinuity.
- No X propagation: every stage has a defined reset value.

Test Plan:
- Reset then D=gp_max_dly=8; ramp i_data=1,2,3... with i_ena=1 every cycle.
  - o_vld rises after the 8th enabled edge, with o_data=1.
  - The next edges give o_data=2,3,...
- i_ld with i_dly=1; i_ena every 4th cycle; i_data=0xA5 then 0x3C.
  - o_data updates only on enabled edges and holds between them (single-FF equivalence).
  - o_vld goes high after the first enabled edge.
- Clamp checks:
  - i_ld with i_dly=0 -> o_dly=1.
  - i_ld with i_dly=63 -> o_dly=8.
  - Both also give o_vld=0 on the next cycle.
- Mid-stream i_clr, with D=4 and o_vld=1:
  - Next cycle: o_data=0, o_vld=0.
  - o_vld is high again 4 enabled edges later, with o_data = the first post-clear sample.
- Simultaneous i_ld (i_dly=3) + i_ena + i_data=0x55:
  - fill=1 and the shift occurs.
  - o_vld rises 2 enabled edges later, with o_data=0x55.
- Assert i_rst_an=0 for one cycle with i_ena=1 and i_clr=1 mid-stream.
  - All outputs return to reset values (o_dly=8).
  - No capture of i_data on that edge.
